// File: rtl/ddf_pkg.sv
// Shared definitions for the DDF accumulator actor and its tag demultiplexer:
// ingress state encoding and tag/payload width derivation.
package ddf_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LATCH = 2'd1,
        ROUTE = 2'd2
    } ingress_state_t;

    // A single flux still needs one tag bit so the token layout stays uniform.
    function automatic int unsigned tag_width(input int unsigned flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int unsigned pay_width(input int unsigned width, input int unsigned flux);
        return width - tag_width(flux);
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Per-flux synchronous FIFO: registered count, head visible combinationally.
// The caller never pushes when full nor pops when empty.
module tag_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = AW + 1
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge ck) begin
        if (push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/tag_demux.sv
// Steers tagged tokens from one upstream FIFO into per-flux FIFOs, stripping the tag.
// A full flux FIFO stalls ingress on that token only; other fluxes keep draining.
module tag_demux
    import ddf_pkg::*;
#(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned TAG_WIDTH = tag_width(FLUX),
    localparam int unsigned PAY_WIDTH = pay_width(WIDTH, FLUX)
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      in0_empty,
    output logic                      in0_read,
    input  logic [WIDTH-1:0]          in0_data,
    input  logic [FLUX-1:0]           out_full,
    output logic [FLUX-1:0]           out_wr,
    output logic [PAY_WIDTH*FLUX-1:0] out_data,
    output logic                      drop_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    ingress_state_t state;
    ingress_state_t state_next;

    logic [TAG_WIDTH-1:0] hold_tag;
    logic [PAY_WIDTH-1:0] hold_pay;
    logic [31:0]          tag_ext;
    logic                 tag_ok;
    logic                 sel_full;
    logic [FLUX-1:0]      sel_vec;
    logic [FLUX-1:0]      push;
    logic [FLUX-1:0]      pop;
    logic [FLUX-1:0]      nonempty;
    logic [CW-1:0]        count [FLUX];
    logic [PAY_WIDTH-1:0] head  [FLUX];

    // Widened so the out-of-range test stays meaningful when FLUX is not a power of two.
    assign tag_ext = 32'(hold_tag);
    assign tag_ok  = tag_ext < FLUX;

    always_comb begin
        sel_vec  = '0;
        sel_full = 1'b0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            if (tag_ext == f) begin
                sel_vec[f] = 1'b1;
                sel_full   = (count[f] == CW'(DEPTH));
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state    <= FETCH;
            hold_tag <= '0;
            hold_pay <= '0;
        end else begin
            state <= state_next;
            if (state == LATCH) begin
                hold_tag <= in0_data[WIDTH-1 -: TAG_WIDTH];
                hold_pay <= in0_data[PAY_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        in0_read   = 1'b0;
        drop_err   = 1'b0;
        push       = '0;
        case (state)
            FETCH: begin
                in0_read = ~in0_empty;
                if (!in0_empty) state_next = LATCH;
            end
            LATCH: begin
                state_next = ROUTE;
            end
            ROUTE: begin
                if (!tag_ok) begin
                    drop_err   = 1'b1;
                    state_next = FETCH;
                end else if (!sel_full) begin
                    // Next upstream read overlaps this push to sustain one token per two cycles.
                    push       = sel_vec;
                    in0_read   = ~in0_empty;
                    state_next = in0_empty ? FETCH : LATCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        if (rst) begin
            in0_read = 1'b0;
            drop_err = 1'b0;
            push     = '0;
        end
    end

    for (genvar f = 0; f < FLUX; f++) begin : g_flux
        tag_fifo #(
            .WIDTH (PAY_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .ck        (ck),
            .rst       (rst),
            .push      (push[f]),
            .push_data (hold_pay),
            .pop       (pop[f]),
            .head      (head[f]),
            .count     (count[f])
        );

        assign nonempty[f] = (count[f] != '0) & ~rst;
        assign out_wr[f]   = nonempty[f] & ~out_full[f];
        assign pop[f]      = out_wr[f];
        assign out_data[f*PAY_WIDTH +: PAY_WIDTH] = nonempty[f] ? head[f] : '0;
    end

endmodule
